// File: rtl/neuron_layer_acc.sv
// Bank of LAYER_SZ signed Q(SIZE-FRAC).FRAC neurons supporting LOAD, ACC, MAC and a multi-cycle ReLU sweep.
// Define LAYER_SAT_EN to make ACC/MAC saturate instead of wrapping modulo 2^SIZE.
module neuron_layer_acc #(
    parameter int SIZE     = 16,
    parameter int FRAC     = 8,
    parameter int LAYER_SZ = 2,
    parameter int ADDR_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_op,
    input  logic [SIZE-1:0]          i_load_value,
    input  logic [SIZE-1:0]          i_load_weight,
    input  logic [ADDR_W-1:0]        i_load_address,
    output logic [LAYER_SZ*SIZE-1:0] o_values,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_MAC  = 2'b10;
    localparam logic [1:0] OP_ACT  = 2'b11;

    localparam int               IDX_W    = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_SZ - 1);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;

    logic                   w_accept;
    logic                   w_addr_ok;
    logic                   w_write;
    logic [SIZE-1:0]        w_cur;
    logic [SIZE-1:0]        w_opnd;
    logic [SIZE-1:0]        w_result;
    logic signed [2*SIZE-1:0] w_prod;
    logic signed [2*SIZE-1:0] w_shift;
    logic [SIZE:0]          w_sum;
    logic                   w_unused;

`ifdef LAYER_SAT_EN
    localparam logic [SIZE-1:0] S_MAX = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic [SIZE-1:0] S_MIN = {1'b1, {(SIZE-1){1'b0}}};

    // Fits in SIZE bits only when every bit from SIZE-1 upward is a copy of the sign.
    function automatic logic [SIZE-1:0] clamp_prod(input logic [2*SIZE-1:0] x);
        if ((&x[2*SIZE-1:SIZE-1]) || (~|x[2*SIZE-1:SIZE-1]))
            return x[SIZE-1:0];
        else
            return x[2*SIZE-1] ? S_MIN : S_MAX;
    endfunction

    function automatic logic [SIZE-1:0] clamp_sum(input logic [SIZE:0] x);
        if (x[SIZE] == x[SIZE-1])
            return x[SIZE-1:0];
        else
            return x[SIZE] ? S_MIN : S_MAX;
    endfunction
`endif

    assign o_cmd_ready = (r_state == S_IDLE) && i_reset;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_addr_ok   = ({1'b0, i_load_address} < (ADDR_W+1)'(LAYER_SZ));
    assign w_write     = w_accept && (i_cmd_op != OP_ACT) && w_addr_ok;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < LAYER_SZ; i++) begin
            if (i_load_address == ADDR_W'(i))
                w_cur = o_values[i*SIZE +: SIZE];
        end
    end

    assign w_prod  = $signed(i_load_value) * $signed(i_load_weight);
    assign w_shift = w_prod >>> FRAC;

    always_comb begin
        w_opnd = i_load_value;
        if (i_cmd_op == OP_MAC) begin
`ifdef LAYER_SAT_EN
            w_opnd = clamp_prod(w_shift);
`else
            w_opnd = w_shift[SIZE-1:0];
`endif
        end
    end

    // Sign-extended by one bit so overflow is visible before narrowing.
    assign w_sum = {w_cur[SIZE-1], w_cur} + {w_opnd[SIZE-1], w_opnd};

    always_comb begin
        w_result = i_load_value;
        if (i_cmd_op == OP_ACC || i_cmd_op == OP_MAC) begin
`ifdef LAYER_SAT_EN
            w_result = clamp_sum(w_sum);
`else
            w_result = w_sum[SIZE-1:0];
`endif
        end
    end

    assign w_unused = ^{w_shift[2*SIZE-1:SIZE], w_sum[SIZE], OP_LOAD};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_cmd_op == OP_ACT) begin
                            r_state <= S_SWEEP;
                            r_idx   <= '0;
                            o_busy  <= 1'b1;
                        end else if (!w_addr_ok) begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One register per neuron; the addressed write and the sweep slot never coincide.
    genvar gi;
    generate
        for (gi = 0; gi < LAYER_SZ; gi++) begin : g_neuron
            logic [SIZE-1:0] r_val;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_val <= '0;
                end else if (w_write && (i_load_address == ADDR_W'(gi))) begin
                    r_val <= w_result;
                end else if ((r_state == S_SWEEP) && (r_idx == IDX_W'(gi)) && r_val[SIZE-1]) begin
                    r_val <= '0;
                end
            end

            assign o_values[gi*SIZE +: SIZE] = r_val;
        end
    endgenerate

endmodule
